pipeline_sample_feeder: RTL

- Initiator side of the pipeline sample handshake (in_sample / in_valid / ready / out_sample).
- Accepts audio samples from a source strobe and buffers them in a small FIFO.
- Issues each sample to the pipeline as a single-cycle tick, waits for processing to complete, captures the result, and emits it as a single-cycle output strobe.
- Sits between the codec-side sample clocking logic and the pipeline top; also reports overruns, timeouts and pipeline faults.

---
 rtl/pipeline_sample_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipeline_sample_feeder.sv
// Initiator side of the pipeline sample handshake: buffers source samples in a
// small FIFO, ticks each one into the pipeline, and strobes out the result.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a buffered sample; pops the FIFO head
// ISSUE      | launches the single-cycle tick, arms the timeout timer
// WAIT_ACK   | waiting for the pipeline to drop ready after the tick
// WAIT_DONE  | waiting for ready to return; captures the result
// COOLDOWN   | one dead cycle while the pipeline settles back to READY
// FAULT      | terminal until reset; FIFO still accepts and counts drops
module pipeline_sample_feeder #(
   parameter int data_width     = 16,
   parameter int fifo_depth     = 4,
   parameter int timeout_cycles = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [data_width-1:0] src_sample,
   input  logic                  src_valid,
   output logic [data_width-1:0] pipe_in_sample,
   output logic                  pipe_in_valid,
   input  logic                  pipe_ready,
   input  logic [data_width-1:0] pipe_out_sample,
   input  logic                  pipe_error,
   output logic [data_width-1:0] dst_sample,
   output logic                  dst_valid,
   output logic                  overrun,
   output logic [15:0]           drop_count,
   output logic                  fault,
   output logic                  busy
);

   localparam int aw = $clog2(fifo_depth);
   localparam int tw = $clog2(timeout_cycles + 1);
   localparam logic [aw:0]   fifo_full_cnt = (aw + 1)'(fifo_depth);
   localparam logic [tw-1:0] timer_load    = tw'(timeout_cycles);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_COOLDOWN  = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic [data_width-1:0] fifo_mem [fifo_depth];
   logic [aw-1:0]         rd_ptr, wr_ptr;
   logic [aw:0]           fifo_cnt;
   logic                  fifo_empty, fifo_full;
   logic                  push, pop, drop;
   logic                  tick, capture, tmr_load, tmr_dec;
   logic [tw-1:0]         timer;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == fifo_full_cnt);
   // A pop in the same cycle frees a slot, so a full FIFO can still take the write.
   assign push = src_valid && (!fifo_full || pop);
   assign drop = src_valid && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= src_sample;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + aw'(1);
         if (pop)  rd_ptr <= rd_ptr + aw'(1);
         if (push && !pop)      fifo_cnt <= fifo_cnt + (aw + 1)'(1);
         else if (pop && !push) fifo_cnt <= fifo_cnt - (aw + 1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tick      = 1'b0;
      capture   = 1'b0;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      if (pipe_error) begin
         state_nxt = ST_FAULT;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tick      = 1'b1;
               tmr_load  = 1'b1;
               state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               tmr_dec = 1'b1;
               if (timer == tw'(1))  state_nxt = ST_FAULT;
               else if (!pipe_ready) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (pipe_ready) begin
                  capture   = 1'b1;
                  state_nxt = ST_COOLDOWN;
               end else begin
                  tmr_dec = 1'b1;
                  if (timer == tw'(1)) state_nxt = ST_FAULT;
               end
            end
            ST_COOLDOWN: state_nxt = ST_IDLE;
            ST_FAULT:    state_nxt = ST_FAULT;
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   // Timer counts down from timeout_cycles; reaching terminal count 1 while
   // still waiting means timeout_cycles edges have elapsed since the tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_in_sample <= '0;
         pipe_in_valid  <= 1'b0;
         dst_sample     <= '0;
         dst_valid      <= 1'b0;
         overrun        <= 1'b0;
         drop_count     <= '0;
         timer          <= '0;
      end else begin
         pipe_in_valid <= tick;
         dst_valid     <= capture;
         overrun       <= drop;
         if (pop)     pipe_in_sample <= fifo_mem[rd_ptr];
         if (capture) dst_sample     <= pipe_out_sample;
         if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         if (tmr_load)                    timer <= timer_load;
         else if (tmr_dec && timer != '0) timer <= timer - tw'(1);
      end
   end

   assign busy  = (state != ST_IDLE);
   assign fault = (state == ST_FAULT);

endmodule
